grad_magdir_pipe: RTL and testbench
===================================

Name: grad_magdir_pipe

Overview:
Parametrised, pipelined gradient magnitude and direction quantiser for the edge-detection datapath. It sits between the Sobel gradient stage and non-maximum suppression. Each accepted (dx, dy) pair produces:
- a saturated magnitude (L1 or alpha-max-beta-min approximation),
- a 4-sector direction code,
- an edge flag against a programmable threshold,
- a per-line edge count.

All stages use valid/ready handshaking with backpressure.

Parameters:
IN_W, 16, two's-complement width of dx and dy
MAG_W, 16, unsigned magnitude output width; the result saturates to 2^MAG_W-1
CNT_W, 12, width of the per-line edge counter; the counter saturates at 2^CNT_W-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high, clears all state
in_valid  in  1  dx/dy/in_last are valid
in_ready  out  1  block can accept this cycle
dx  in  IN_W  horizontal gradient, signed
dy  in  IN_W  vertical gradient, signed
in_last  in  1  marks last pixel of a line
mag_mode  in  1  0 = |dx|+|dy|, 1 = max + (min>>2) + (min>>3)
thresh  in  MAG_W  edge threshold, quasi-static
out_valid  out  1  outputs valid
out_ready  in  1  downstream accepts
magnitude  out  MAG_W  saturated magnitude
dir  out  2  0 = 0 deg, 1 = 45 deg, 2 = 90 deg, 3 = 135 deg
edge  out  1  magnitude >= thresh
out_last  out  1  delayed in_last
edge_count  out  CNT_W  edges in last completed line
count_valid  out  1  one-cycle pulse when edge_count updates

Behaviour:
- Reset values: all outputs 0, pipeline valid bits 0, internal counter 0. in_ready is 1 after reset.
- Reset mid-operation flushes the pipeline with no output. Partial-line count is discarded.
- Handshake and stall:
  - Accept when in_valid && in_ready. Transfer out when out_valid && out_ready.
  - Stall: when out_valid && !out_ready, all stages hold and in_ready = 0. Otherwise in_ready = 1 and every stage advances.
  - Outputs are stable while stalled.
- Latency: 3 cycles from accept to out_valid with no stall; throughput 1 per cycle.
- S1 (absolute value and signs):
  - ax = |dx|, ay = |dy| as IN_W-bit unsigned; the most negative input maps to 2^(IN_W-1) exactly.
  - Register sgn_eq = (dx[IN_W-1] == dy[IN_W-1]); zero counts as positive.
- S2 (compares and raw magnitude):
  - lo = (ay*256 < ax*106) and hi = (ay*256 > ax*618), using tan22.5 ~ 106/256 and tan67.5 ~ 618/256.
  - Products are IN_W+10 bits and must not truncate.
  - Raw magnitude, IN_W+1 bits:
    - mode 0: ax+ay.
    - mode 1: mx + (mn>>2) + (mn>>3), where mx = max(ax, ay) and mn = min(ax, ay).
  - mag_mode is sampled at accept and carried with the data.
- S3 (saturate and classify):
  - Saturate to MAG_W bits.
  - dir = 0 if lo, else 2 if hi, else (sgn_eq ? 1 : 3).
  - Equality at either boundary gives a diagonal direction. dx = dy = 0 gives dir 0, magnitude 0.
  - edge = (magnitude >= thresh), with thresh sampled at S3 advance.
- Edge counter:
  - Increments on each output transfer with edge = 1, saturating at 2^CNT_W-1.
  - On a transfer with out_last = 1: edge_count <= running count including that pixel, count_valid pulses for one cycle, and the running count clears to 0.
  - edge_count holds its value otherwise.

Test Plan:
- Directions: dx=100, dy=0 -> dir 0, magnitude 100. dx=100, dy=100 -> dir 1. dx=-100, dy=100 -> dir 3. dx=0, dy=-50 -> dir 2, magnitude 50. Each appears 3 cycles after accept.
- Modes and boundary: dx=dy=100 gives magnitude 200 in mode 0 and 137 in mode 1. dx=256, dy=106 (exactly on the tan22.5 boundary) -> dir 1.
- Saturation and extremes: dx=dy=-32768, mode 0 -> magnitude 65535, dir 1. dx=dy=0 -> magnitude 0, dir 0, edge 0 with thresh=1.
- Backpressure: stream 8 pixels, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, outputs frozen, no loss or duplication, order preserved.
- Edge count: thresh=150, 6-pixel line with magnitudes {100, 200, 150, 0, 300, 149} and in_last on pixel 6 -> edge_count=3 and count_valid pulses once on the pixel-6 transfer. The next line's count starts from 0.
- Reset: assert rst with 2 pixels in flight -> out_valid=0 immediately and no outputs emerge after release. A subsequent line counts from 0.

Source files
------------

// File: rtl/grad_magdir_pipe_if.sv
// rtl/grad_magdir_pipe_if.sv - gradient pair in, magnitude/direction/edge out, handshake bundle
interface grad_magdir_pipe_if #(
    parameter int IN_W  = 16,
    parameter int MAG_W = 16,
    parameter int CNT_W = 12
);
    logic                   in_valid;
    logic                   in_ready;
    logic signed [IN_W-1:0] dx;
    logic signed [IN_W-1:0] dy;
    logic                   in_last;
    logic                   mag_mode;
    logic [MAG_W-1:0]       thresh;
    logic                   out_valid;
    logic                   out_ready;
    logic [MAG_W-1:0]       magnitude;
    logic [1:0]             dir;
    logic                   edge_flag;
    logic                   out_last;
    logic [CNT_W-1:0]       edge_count;
    logic                   count_valid;

    modport slave (
        input  in_valid, dx, dy, in_last, mag_mode, thresh, out_ready,
        output in_ready, out_valid, magnitude, dir, edge_flag, out_last,
               edge_count, count_valid
    );

    modport master (
        output in_valid, dx, dy, in_last, mag_mode, thresh, out_ready,
        input  in_ready, out_valid, magnitude, dir, edge_flag, out_last,
               edge_count, count_valid
    );
endinterface

// File: rtl/grad_magdir_pipe.sv
// rtl/grad_magdir_pipe.sv - 3-stage gradient magnitude, 4-sector direction, edge flag and per-line edge count
module grad_magdir_pipe #(
    parameter int IN_W  = 16,
    parameter int MAG_W = 16,
    parameter int CNT_W = 12
) (
    input logic               clk,
    input logic               rst,
    grad_magdir_pipe_if.slave bus
);
    localparam int RW = IN_W + 1;
    localparam int PW = IN_W + 10;
    localparam int SW = (RW > MAG_W) ? RW + 1 : MAG_W + 1;

    logic             advance;
    logic             xfer;
    logic [IN_W-1:0]  dx_u, dy_u;
    logic [IN_W-1:0]  mx, mn;
    logic [PW-1:0]    ay_sh, ax_lo, ax_hi;
    logic [SW-1:0]    raw_ext;
    logic [MAG_W-1:0] sat_mag;
    logic [CNT_W-1:0] cnt_inc;

    logic             s1_v_q, s1_v_d, s1_sgn_eq_q, s1_sgn_eq_d;
    logic             s1_mode_q, s1_mode_d, s1_last_q, s1_last_d;
    logic [IN_W-1:0]  s1_ax_q, s1_ax_d, s1_ay_q, s1_ay_d;

    logic             s2_v_q, s2_v_d, s2_lo_q, s2_lo_d, s2_hi_q, s2_hi_d;
    logic             s2_zero_q, s2_zero_d, s2_sgn_eq_q, s2_sgn_eq_d, s2_last_q, s2_last_d;
    logic [RW-1:0]    s2_raw_q, s2_raw_d;

    logic             s3_v_q, s3_v_d, s3_edge_q, s3_edge_d, s3_last_q, s3_last_d;
    logic [MAG_W-1:0] s3_mag_q, s3_mag_d;
    logic [1:0]       s3_dir_q, s3_dir_d;

    logic [CNT_W-1:0] cnt_q, cnt_d, edge_count_q, edge_count_d;
    logic             count_valid_q, count_valid_d;

    always_comb begin
        // Every stage moves together unless the output register is holding an unaccepted result.
        advance = !(s3_v_q && !bus.out_ready);
        xfer    = s3_v_q && bus.out_ready;
        dx_u    = bus.dx;
        dy_u    = bus.dy;

        s1_v_d      = bus.in_valid;
        s1_ax_d     = dx_u[IN_W-1] ? (~dx_u + IN_W'(1)) : dx_u;
        s1_ay_d     = dy_u[IN_W-1] ? (~dy_u + IN_W'(1)) : dy_u;
        s1_sgn_eq_d = (dx_u[IN_W-1] == dy_u[IN_W-1]);
        s1_mode_d   = bus.mag_mode;
        s1_last_d   = bus.in_last;

        mx    = (s1_ax_q >= s1_ay_q) ? s1_ax_q : s1_ay_q;
        mn    = (s1_ax_q >= s1_ay_q) ? s1_ay_q : s1_ax_q;
        // Sector boundaries: tan22.5 ~ 106/256, tan67.5 ~ 618/256, compared at full product width.
        ay_sh = PW'(s1_ay_q) << 8;
        ax_lo = PW'(s1_ax_q) * PW'(106);
        ax_hi = PW'(s1_ax_q) * PW'(618);

        s2_v_d      = s1_v_q;
        s2_lo_d     = (ay_sh < ax_lo);
        s2_hi_d     = (ay_sh > ax_hi);
        s2_zero_d   = (s1_ax_q == '0) && (s1_ay_q == '0);
        s2_sgn_eq_d = s1_sgn_eq_q;
        s2_last_d   = s1_last_q;
        s2_raw_d    = s1_mode_q ? (RW'(mx) + RW'(mn >> 2) + RW'(mn >> 3))
                                : (RW'(s1_ax_q) + RW'(s1_ay_q));

        raw_ext = SW'(s2_raw_q);
        sat_mag = (raw_ext > SW'({MAG_W{1'b1}})) ? {MAG_W{1'b1}} : MAG_W'(raw_ext);

        s3_v_d    = s2_v_q;
        s3_mag_d  = sat_mag;
        s3_edge_d = (sat_mag >= bus.thresh);
        s3_last_d = s2_last_q;
        if (s2_zero_q || s2_lo_q) begin
            s3_dir_d = 2'd0;
        end else if (s2_hi_q) begin
            s3_dir_d = 2'd2;
        end else begin
            s3_dir_d = s2_sgn_eq_q ? 2'd1 : 2'd3;
        end

        cnt_inc       = (s3_edge_q && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
        count_valid_d = xfer && s3_last_q;
        edge_count_d  = count_valid_d ? cnt_inc : edge_count_q;
        cnt_d         = cnt_q;
        if (xfer) begin
            cnt_d = s3_last_q ? '0 : cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q        <= 1'b0;
            s1_ax_q       <= '0;
            s1_ay_q       <= '0;
            s1_sgn_eq_q   <= 1'b0;
            s1_mode_q     <= 1'b0;
            s1_last_q     <= 1'b0;
            s2_v_q        <= 1'b0;
            s2_lo_q       <= 1'b0;
            s2_hi_q       <= 1'b0;
            s2_zero_q     <= 1'b0;
            s2_sgn_eq_q   <= 1'b0;
            s2_last_q     <= 1'b0;
            s2_raw_q      <= '0;
            s3_v_q        <= 1'b0;
            s3_mag_q      <= '0;
            s3_dir_q      <= '0;
            s3_edge_q     <= 1'b0;
            s3_last_q     <= 1'b0;
            cnt_q         <= '0;
            edge_count_q  <= '0;
            count_valid_q <= 1'b0;
        end else begin
            if (advance) begin
                s1_v_q      <= s1_v_d;
                s1_ax_q     <= s1_ax_d;
                s1_ay_q     <= s1_ay_d;
                s1_sgn_eq_q <= s1_sgn_eq_d;
                s1_mode_q   <= s1_mode_d;
                s1_last_q   <= s1_last_d;
                s2_v_q      <= s2_v_d;
                s2_lo_q     <= s2_lo_d;
                s2_hi_q     <= s2_hi_d;
                s2_zero_q   <= s2_zero_d;
                s2_sgn_eq_q <= s2_sgn_eq_d;
                s2_last_q   <= s2_last_d;
                s2_raw_q    <= s2_raw_d;
                s3_v_q      <= s3_v_d;
                s3_mag_q    <= s3_mag_d;
                s3_dir_q    <= s3_dir_d;
                s3_edge_q   <= s3_edge_d;
                s3_last_q   <= s3_last_d;
            end
            cnt_q         <= cnt_d;
            edge_count_q  <= edge_count_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign bus.in_ready    = advance;
    assign bus.out_valid   = s3_v_q;
    assign bus.magnitude   = s3_mag_q;
    assign bus.dir         = s3_dir_q;
    assign bus.edge_flag   = s3_edge_q;
    assign bus.out_last    = s3_last_q;
    assign bus.edge_count  = edge_count_q;
    assign bus.count_valid = count_valid_q;
endmodule

// File: tb/tb_grad_magdir_pipe.sv
// tb/tb_grad_magdir_pipe.sv - vector table and scoreboard bench for grad_magdir_pipe
module tb_grad_magdir_pipe;
    localparam int IN_W  = 16;
    localparam int MAG_W = 16;
    localparam int CNT_W = 12;

    typedef struct {
        logic [IN_W-1:0]  dx;
        logic [IN_W-1:0]  dy;
        logic             mode;
        logic             last;
        logic [MAG_W-1:0] mag;
        logic [1:0]       dir;
        logic             edg;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   n_cv  = 0;
    vec_t exp_q[$];
    int   cq[$];
    vec_t tbl[16];
    vec_t e;

    grad_magdir_pipe_if #(.IN_W(IN_W), .MAG_W(MAG_W), .CNT_W(CNT_W)) bus ();
    grad_magdir_pipe #(.IN_W(IN_W), .MAG_W(MAG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int dx, input int dy, input bit md, input bit lst,
                                input int mag, input int dr, input bit eg);
        vec_t r;
        r.dx   = IN_W'(dx);
        r.dy   = IN_W'(dy);
        r.mode = md;
        r.last = lst;
        r.mag  = MAG_W'(mag);
        r.dir  = 2'(dr);
        r.edg  = eg;
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the pixel has been accepted.
    task automatic drive_px(input vec_t v, input bit push);
        int k;
        bus.dx       = v.dx;
        bus.dy       = v.dy;
        bus.mag_mode = v.mode;
        bus.in_last  = v.last;
        bus.in_valid = 1'b1;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            k++;
            if (k > 100) begin
                chk("accept_timeout", 1, 0);
                bus.in_valid = 1'b0;
                return;
            end
        end
        if (push) exp_q.push_back(v);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || cq.size() != 0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pixels_left", exp_q.size(), 0);
        chk("drain_counts_left", cq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output_mag", bus.magnitude, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("magnitude", bus.magnitude, e.mag);
                    chk("dir", bus.dir, e.dir);
                    chk("edge", bus.edge_flag, e.edg);
                    chk("out_last", bus.out_last, e.last);
                end
            end
            if (bus.count_valid) begin
                n_cv++;
                if (cq.size() == 0) chk("unexpected_count_valid", bus.edge_count, 32'hFFFF_FFFF);
                else chk("edge_count", bus.edge_count, cq.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ecount, cv0, out0;
        logic [MAG_W-1:0] snap;

        bus.in_valid  = 1'b0;
        bus.dx        = '0;
        bus.dy        = '0;
        bus.in_last   = 1'b0;
        bus.mag_mode  = 1'b0;
        bus.thresh    = MAG_W'(150);
        bus.out_ready = 1'b1;

        tbl[0]  = mk(100, 0, 0, 0, 100, 0, 0);
        tbl[1]  = mk(100, 100, 0, 0, 200, 1, 1);
        tbl[2]  = mk(-100, 100, 0, 0, 200, 3, 1);
        tbl[3]  = mk(0, -50, 0, 0, 50, 2, 0);
        tbl[4]  = mk(100, 100, 1, 0, 137, 1, 0);
        tbl[5]  = mk(256, 106, 0, 0, 362, 1, 1);
        tbl[6]  = mk(256, 618, 0, 0, 874, 1, 1);
        tbl[7]  = mk(-32768, -32768, 0, 0, 65535, 1, 1);
        tbl[8]  = mk(-32768, -32768, 1, 0, 45056, 1, 1);
        tbl[9]  = mk(32767, -32768, 0, 0, 65535, 3, 1);
        tbl[10] = mk(-3, 7, 0, 0, 10, 3, 0);
        tbl[11] = mk(-3, 7, 1, 0, 7, 3, 0);
        tbl[12] = mk(1000, -2, 1, 0, 1000, 0, 1);
        tbl[13] = mk(10, -40, 0, 0, 50, 2, 0);
        tbl[14] = mk(150, 0, 0, 0, 150, 0, 1);
        tbl[15] = mk(0, 0, 0, 1, 0, 0, 0);

        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", bus.out_valid, 0);
        chk("post_rst_count_valid", bus.count_valid, 0);
        chk("post_rst_edge_count", bus.edge_count, 0);
        chk("post_rst_magnitude", bus.magnitude, 0);
        chk("post_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Pixel presented in cycle c must show out_valid in cycle c+3.
        drive_px(mk(100, 0, 0, 0, 100, 0, 0), 1'b1);
        @(negedge clk);
        chk("latency_cycle1", bus.out_valid, 0);
        @(negedge clk);
        chk("latency_cycle2", bus.out_valid, 0);
        @(negedge clk);
        chk("latency_cycle3", bus.out_valid, 1);
        @(posedge clk);
        #1;
        drain();

        ecount = 0;
        foreach (tbl[i]) ecount += int'(tbl[i].edg);
        cq.push_back(ecount);
        foreach (tbl[i]) drive_px(tbl[i], 1'b1);
        drain();

        bus.thresh = MAG_W'(1);
        cq.push_back(1);
        drive_px(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);
        drive_px(mk(1, 0, 0, 1, 1, 0, 1), 1'b1);
        drain();

        bus.thresh = MAG_W'(150);
        cv0 = n_cv;
        cq.push_back(3);
        drive_px(mk(100, 0, 0, 0, 100, 0, 0), 1'b1);
        drive_px(mk(200, 0, 0, 0, 200, 0, 1), 1'b1);
        drive_px(mk(150, 0, 0, 0, 150, 0, 1), 1'b1);
        drive_px(mk(0, 0, 0, 0, 0, 0, 0), 1'b1);
        drive_px(mk(300, 0, 0, 0, 300, 0, 1), 1'b1);
        drive_px(mk(149, 0, 0, 1, 149, 0, 0), 1'b1);
        drain();
        chk("line_count_valid_pulses", n_cv - cv0, 1);
        cq.push_back(1);
        drive_px(mk(200, 0, 0, 0, 200, 0, 1), 1'b1);
        drive_px(mk(50, 0, 0, 1, 50, 0, 0), 1'b1);
        drain();

        out0 = n_out;
        cq.push_back(4);
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive_px(mk(i * 37 + 5, 0, 0, (i == 7) ? 1 : 0, i * 37 + 5, 0,
                                (i * 37 + 5 >= 150) ? 1 : 0), 1'b1);
            end
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                @(negedge clk);
                snap = bus.magnitude;
                chk("stall_in_ready", bus.in_ready, 0);
                chk("stall_out_valid", bus.out_valid, 1);
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    chk("stall_in_ready", bus.in_ready, 0);
                    chk("stall_out_valid", bus.out_valid, 1);
                    chk("stall_mag_frozen", bus.magnitude, snap);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_outputs", n_out - out0, 8);

        cv0 = n_cv;
        drive_px(mk(200, 0, 0, 0, 200, 0, 1), 1'b1);
        drain();
        bus.out_ready = 1'b0;
        drive_px(mk(300, 0, 0, 0, 300, 0, 1), 1'b0);
        drive_px(mk(400, 0, 0, 0, 400, 0, 1), 1'b0);
        drive_px(mk(500, 0, 0, 0, 500, 0, 1), 1'b0);
        @(negedge clk);
        chk("pre_rst_out_valid", bus.out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_flush_out_valid", bus.out_valid, 0);
        chk("rst_flush_in_ready", bus.in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        out0 = n_out;
        bus.out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_no_outputs", n_out - out0, 0);
        @(posedge clk);
        #1;
        cq.push_back(1);
        drive_px(mk(300, 0, 0, 1, 300, 0, 1), 1'b1);
        drain();
        chk("rst_line_count_pulses", n_cv - cv0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
